// File: rtl/cmd_seq_pkg.sv
// Shared types for the Knight command sequencer: FSM states, failure codes, command word.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    ERROR
  } seq_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NAK     = 2'b10;

  typedef logic [15:0] knight_cmd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'h0001;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// DEPTH x 16 command queue; head is combinational from storage, push/pop take effect at the clock.
// Push while full is rejected (no bypass even when popping the same cycle); pop while empty is ignored.
module cmd_fifo
  import cmd_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  knight_cmd_t              push_dat,
  input  logic                     pop,
  output knight_cmd_t              head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  knight_cmd_t  mem_q [DEPTH];
  knight_cmd_t  mem_d [DEPTH];
  logic         wr_en;
  logic         rd_en;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(rd_en);
    mem_d    = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Issues queued Knight commands one at a time to RemoteComm, retiring on ACK and retrying on NAK/timeout.
// cmd/send_cmd appear one cycle after SEND; statistics counters exist only with CMD_SEQ_STATS_EN defined.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int          DEPTH          = 4,
  parameter logic [7:0]  ACK_VAL        = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 5_000_000,
  parameter int          MAX_RETRY      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [15:0]              push_cmd,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovfl,
  input  logic                     en,
  output logic [15:0]              cmd,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     err,
  output logic [1:0]               err_code,
  input  logic                     clr_err,
  output logic [15:0]              sent_cnt,
  output logic [15:0]              retry_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  seq_state_t   state_q, state_d;
  knight_cmd_t  cmd_q, cmd_d;
  logic         send_q, send_d;
  logic         ovfl_q, ovfl_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic         err_q, err_d;
  logic [1:0]   code_q, code_d;
  logic         pop;
  logic         empty;
  knight_cmd_t  head_dat;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    send_d  = 1'b0;
    timer_d = timer_q;
    retry_d = retry_q;
    err_d   = err_q;
    code_d  = code_q;
    pop     = 1'b0;
    ovfl_d  = push & full;
    case (state_q)
      IDLE: begin
        if (en && !empty) state_d = SEND;
      end
      SEND: begin
        cmd_d   = head_dat;
        send_d  = 1'b1;
        state_d = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (cmd_sent) begin
          timer_d = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        timer_d = timer_q + 1'b1;
        // A response arriving on the timeout cycle takes precedence over the timeout.
        if (resp_rdy && resp == ACK_VAL) begin
          pop     = 1'b1;
          retry_d = '0;
          state_d = IDLE;
        end else if (resp_rdy || timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end else begin
            err_d   = 1'b1;
            code_d  = resp_rdy ? ERR_NAK : ERR_TIMEOUT;
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        if (clr_err) begin
          pop     = 1'b1;
          retry_d = '0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      send_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      timer_q <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      send_q  <= send_d;
      ovfl_q  <= ovfl_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign cmd      = cmd_q;
  assign send_cmd = send_q;
  assign ovfl     = ovfl_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign err_code = code_q;

`ifdef CMD_SEQ_STATS_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;
  logic [15:0] retry_cnt_q, retry_cnt_d;
  logic        ack_evt;
  logic        rty_evt;

  assign ack_evt = (state_q == WAIT_RESP) && (state_d == IDLE);
  assign rty_evt = (state_q == WAIT_RESP) && (state_d == SEND);

  always_comb begin
    sent_cnt_d  = ack_evt ? sat_inc16(sent_cnt_q) : sent_cnt_q;
    retry_cnt_d = rty_evt ? sat_inc16(retry_cnt_q) : retry_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      sent_cnt_q  <= sent_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign sent_cnt  = sent_cnt_q;
  assign retry_cnt = retry_cnt_q;
`else
  assign sent_cnt  = 16'h0000;
  assign retry_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: acts as RemoteComm and checks outputs against a queue-based protocol model.
module tb_cmd_sequencer;
  import cmd_seq_pkg::*;

  localparam int         DEPTH = 4;
  localparam int         TO    = 1000;
  localparam int         MAXR  = 2;
  localparam logic [7:0] ACK   = 8'hA5;
`ifdef CMD_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push;
  logic [15:0] push_cmd;
  logic        full;
  logic [2:0]  count;
  logic        ovfl;
  logic        en;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;
  logic        clr_err;
  logic [15:0] sent_cnt;
  logic [15:0] retry_cnt;

  cmd_sequencer #(
    .DEPTH(DEPTH), .ACK_VAL(ACK), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd), .full(full),
    .count(count), .ovfl(ovfl), .en(en), .cmd(cmd), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .busy(busy),
    .err(err), .err_code(err_code), .clr_err(clr_err), .sent_cnt(sent_cnt),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Protocol model: accepted commands in order, whether a response is awaited, and the stats.
  knight_cmd_t mq[$];
  bit          m_await;
  int          m_wt;
  int          m_tries;
  logic        m_err;
  logic [1:0]  m_code;
  logic        m_ovfl;
  logic [15:0] m_sent;
  logic [15:0] m_retry;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_await = 0; m_wt = 0; m_tries = 0;
      m_err = 0; m_code = ERR_NONE; m_ovfl = 0;
      m_sent = 0; m_retry = 0;
    end else begin
      bit was_full;
      bit do_pop;
      bit fail;
      was_full = (mq.size() == DEPTH);
      m_ovfl   = push && was_full;
      do_pop   = 0;
      fail     = 0;
      if (m_await) begin
        if (resp_rdy && resp == ACK) begin
          do_pop = 1; m_await = 0; m_tries = 0; m_sent = sat16(m_sent);
        end else if (resp_rdy || m_wt == TO - 1) begin
          fail = 1;
        end else begin
          m_wt++;
        end
      end else if (cmd_sent) begin
        m_await = 1; m_wt = 0;
      end
      if (fail) begin
        m_await = 0;
        if (m_tries < MAXR) begin
          m_tries++; m_retry = sat16(m_retry);
        end else begin
          m_err = 1; m_code = resp_rdy ? ERR_NAK : ERR_TIMEOUT;
        end
      end
      if (m_err && clr_err) begin
        do_pop = 1; m_err = 0; m_code = ERR_NONE; m_tries = 0;
      end
      if (do_pop) void'(mq.pop_front());
      if (push && !was_full) mq.push_back(push_cmd);
    end
  end

  knight_cmd_t sent_log[$];
  logic        prev_send = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", {29'd0, count}, mq.size());
      chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
      chk("ovfl", {31'd0, ovfl}, {31'd0, m_ovfl});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("err_code", {30'd0, err_code}, {30'd0, m_code});
      chk("sent_cnt", {16'd0, sent_cnt}, STATS ? {16'd0, m_sent} : 32'd0);
      chk("retry_cnt", {16'd0, retry_cnt}, STATS ? {16'd0, m_retry} : 32'd0);
      if (send_cmd) begin
        sent_log.push_back(cmd);
        chk("send_overlap", {31'd0, m_await}, 32'd0);
        chk("send_pulse_len", {31'd0, prev_send}, 32'd0);
        chk("send_nonempty", {31'd0, mq.size() != 0}, 32'd1);
        if (mq.size() != 0) chk("cmd_head", {16'd0, cmd}, {16'd0, mq[0]});
      end
      prev_send = send_cmd;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_push(input knight_cmd_t c);
    push = 1'b1; push_cmd = c;
    step();
    push = 1'b0;
  endtask

  task automatic wait_send(input string tag, input int budget);
    int n = 0;
    while (!send_cmd && n < budget) begin
      step(); n++;
    end
    if (!send_cmd) bound_fail(tag);
  endtask

  // RemoteComm stand-in: report transmit done, then optionally answer two cycles later.
  task automatic serve(input bit answer, input logic [7:0] r);
    cmd_sent = 1'b1;
    step();
    cmd_sent = 1'b0;
    step();
    if (answer) begin
      resp_rdy = 1'b1; resp = r;
      step();
      resp_rdy = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(); n++;
    end
    if (busy) bound_fail(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, {29'd0, count}, 32'd0);
    chk({tag, "_full"}, {31'd0, full}, 32'd0);
    chk({tag, "_cmd"}, {16'd0, cmd}, 32'd0);
    chk({tag, "_send"}, {31'd0, send_cmd}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_code"}, {30'd0, err_code}, 32'd0);
    chk({tag, "_ovfl"}, {31'd0, ovfl}, 32'd0);
    chk({tag, "_sent"}, {16'd0, sent_cnt}, 32'd0);
    chk({tag, "_retry"}, {16'd0, retry_cnt}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    knight_cmd_t t2_exp [3];
    knight_cmd_t t5_exp [4];
    t2_exp = '{16'h4BF1, 16'h3FF1, 16'h5BF1};
    t5_exp = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};

    rst_n = 1'b0; push = 1'b0; push_cmd = '0; en = 1'b0;
    cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0; clr_err = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // 1: single command acknowledged
    en = 1'b1;
    do_push(16'h2000);
    wait_send("t1_send", 20);
    serve(1'b1, ACK);
    wait_idle("t1_idle", 20);
    chk("t1_sends", sent_log.size(), 32'd1);
    chk("t1_cmd", {16'd0, sent_log[0]}, 32'h2000);
    chk("t1_count", {29'd0, count}, 32'd0);
    chk("t1_sent_cnt", {16'd0, sent_cnt}, STATS ? 32'd1 : 32'd0);

    // 2: three commands in push order
    base = sent_log.size();
    do_push(t2_exp[0]); do_push(t2_exp[1]); do_push(t2_exp[2]);
    for (int i = 0; i < 3; i++) begin
      wait_send("t2_send", 20);
      serve(1'b1, ACK);
    end
    wait_idle("t2_idle", 20);
    chk("t2_sends", sent_log.size() - base, 32'd3);
    for (int i = 0; i < 3; i++)
      if (base + i < sent_log.size()) chk("t2_order", {16'd0, sent_log[base+i]}, {16'd0, t2_exp[i]});
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk("t2_sent_cnt", {16'd0, sent_cnt}, STATS ? 32'd4 : 32'd0);

    // 3: NAK then ACK
    base = sent_log.size();
    do_push(16'h1234);
    wait_send("t3_send1", 20);
    serve(1'b1, 8'h5A);
    wait_send("t3_send2", 20);
    serve(1'b1, ACK);
    wait_idle("t3_idle", 20);
    chk("t3_sends", sent_log.size() - base, 32'd2);
    chk("t3_retry_cnt", {16'd0, retry_cnt}, STATS ? 32'd1 : 32'd0);
    chk("t3_err", {31'd0, err}, 32'd0);
    chk("t3_count", {29'd0, count}, 32'd0);

    // 4: never respond -> two retries, then timeout error
    base = sent_log.size();
    do_push(16'h7777);
    for (int i = 0; i < 3; i++) begin
      wait_send("t4_send", TO + 100);
      serve(1'b0, 8'h00);
    end
    n = 0;
    while (!err && n < TO + 100) begin
      step(); n++;
    end
    if (!err) bound_fail("t4_err_wait");
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_code", {30'd0, err_code}, 32'd1);
    chk("t4_retry_cnt", {16'd0, retry_cnt}, STATS ? 32'd3 : 32'd0);
    repeat (20) step();
    chk("t4_sends", sent_log.size() - base, 32'd3);
    chk("t4_busy_err", {31'd0, busy}, 32'd1);
    chk("t4_count_err", {29'd0, count}, 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    step();
    chk("t4_count_clr", {29'd0, count}, 32'd0);
    chk("t4_busy_clr", {31'd0, busy}, 32'd0);
    chk("t4_err_clr", {31'd0, err}, 32'd0);
    chk("t4_code_clr", {30'd0, err_code}, 32'd0);

    // 5: fill with launches disabled, overflow on the fifth push, then drain
    en = 1'b0;
    base = sent_log.size();
    for (int i = 0; i < 4; i++) do_push(t5_exp[i]);
    chk("t5_full", {31'd0, full}, 32'd1);
    chk("t5_count4", {29'd0, count}, 32'd4);
    push = 1'b1; push_cmd = 16'hA005;
    step();
    push = 1'b0;
    chk("t5_ovfl", {31'd0, ovfl}, 32'd1);
    chk("t5_count_ovfl", {29'd0, count}, 32'd4);
    step();
    chk("t5_ovfl_pulse", {31'd0, ovfl}, 32'd0);
    chk("t5_no_send", sent_log.size() - base, 32'd0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_send("t5_send", 20);
      serve(1'b1, ACK);
    end
    wait_idle("t5_idle", 20);
    chk("t5_sends", sent_log.size() - base, 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < sent_log.size()) chk("t5_order", {16'd0, sent_log[base+i]}, {16'd0, t5_exp[i]});

    // 6: reset while waiting for a response
    base = sent_log.size();
    do_push(16'hBEEF);
    wait_send("t6_send", 20);
    cmd_sent = 1'b1;
    step();
    cmd_sent = 1'b0;
    step();
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_rst");
    step();
    rst_n = 1'b1;
    step();
    resp_rdy = 1'b1; resp = ACK;
    step();
    resp_rdy = 1'b0;
    repeat (3) step();
    chk("t6_count", {29'd0, count}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_sent_cnt", {16'd0, sent_cnt}, 32'd0);
    chk("t6_no_send", sent_log.size() - base, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
